// File: rtl/axis_rti_line_packer_if.sv
// AXI-Stream bundle for the RTI line packer. The master view carries the
// framed output (tlast/tuser); the slave view is the raw magnitude input,
// which has no framing of its own.
interface axis_rti_line_packer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned USER_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_rti_line_packer.sv
// Packs {down, up} magnitude pairs from the RTI readout into AXI-Stream lines.
// Beats are framed (tlast / line index) as they enter a small FWFT FIFO; the
// source ignores backpressure, so beats arriving while full are dropped and
// counted without disturbing the framing.
module axis_rti_line_packer #(
    parameter int unsigned MAG_WIDTH       = 16,
    parameter int unsigned LINE_LEN_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [LINE_LEN_WIDTH-1:0] cfg_line_len,
    axis_rti_line_packer_if.slave     s_axis,
    axis_rti_line_packer_if.master    m_axis,
    output logic [31:0]               sts_drop_count
);
    localparam int unsigned DATA_W  = 2 * MAG_WIDTH;
    localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int unsigned ENTRY_W = 16 + 1 + DATA_W;

    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;
    typedef logic [LINE_LEN_WIDTH-1:0]  len_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam len_t LEN_ONE   = len_t'(1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    ptr_t               wr_ptr;
    ptr_t               rd_ptr;
    cnt_t               count;

    len_t               pos;
    len_t               len;
    len_t               cfg_len_min1;
    len_t               len_eff;
    logic [15:0]        line_idx;
    logic [31:0]        drop_cnt;

    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    logic               tlast_in;

    assign full  = (count == DEPTH_CNT);
    assign push  = s_axis.tvalid && !full;
    assign drop  = s_axis.tvalid && full;
    assign pop   = m_axis.tvalid && m_axis.tready;

    assign s_axis.tready  = !full && !areset;
    assign m_axis.tvalid  = (count != '0);
    // Head entry is only presented while valid so outputs read zero when empty.
    assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = m_axis.tvalid ? mem[rd_ptr] : '0;
    assign sts_drop_count = drop_cnt;

    // Line length for the incoming beat: freshly latched config at a line start.
    always_comb begin
        cfg_len_min1 = (cfg_line_len == '0) ? LEN_ONE : cfg_line_len;
        len_eff      = (pos == '0) ? cfg_len_min1 : len;
        tlast_in     = (pos == (len_eff - LEN_ONE));
    end

    // FIFO storage write; contents need no reset because pointers/count do.
    always_ff @(posedge aclk) begin
        if (!areset && push) begin
            mem[wr_ptr] <= {line_idx, tlast_in, s_axis.tdata};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Line framing advances on accepted beats only.
    always_ff @(posedge aclk) begin
        if (areset) begin
            pos      <= '0;
            len      <= '0;
            line_idx <= '0;
        end else if (push) begin
            if (pos == '0) len <= cfg_len_min1;
            if (tlast_in) begin
                pos      <= '0;
                line_idx <= line_idx + 16'd1;
            end else begin
                pos <= pos + LEN_ONE;
            end
        end
    end

    // Saturating count of beats dropped while the FIFO was full.
    always_ff @(posedge aclk) begin
        if (areset) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_axis_rti_line_packer.sv
// Directed bench for axis_rti_line_packer: a cycle table for framing and
// config changes, plus hand-written overflow, backpressure, reset and wrap runs.
module tb_axis_rti_line_packer;
    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [11:0] cfg_line_len = 12'd4;
    logic [31:0] sts_drop_count;

    axis_rti_line_packer_if #(.DATA_WIDTH(32), .USER_WIDTH(16)) s_if ();
    axis_rti_line_packer_if #(.DATA_WIDTH(32), .USER_WIDTH(16)) m_if ();

    axis_rti_line_packer #(
        .MAG_WIDTH(16),
        .LINE_LEN_WIDTH(12),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .aclk(aclk),
        .areset(areset),
        .cfg_line_len(cfg_line_len),
        .s_axis(s_if),
        .m_axis(m_if),
        .sts_drop_count(sts_drop_count)
    );

    always #5 aclk = ~aclk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        vin;
        logic [31:0] din;
        logic        rdy;
        logic [11:0] cfg;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [15:0] eu;
        logic        esr;
        logic [31:0] edrop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic vin, input logic [31:0] din,
                                input logic rdy, input logic [11:0] cfg, input logic ev,
                                input logic [31:0] ed, input logic el, input logic [15:0] eu,
                                input logic esr, input logic [31:0] edrop);
        vec_t v;
        v.rst = rst; v.vin = vin; v.din = din; v.rdy = rdy; v.cfg = cfg;
        v.ev = ev; v.ed = ed; v.el = el; v.eu = eu; v.esr = esr; v.edrop = edrop;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge aclk);
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        int unsigned sent;
        int unsigned rcv;
        int unsigned nlast;
        int unsigned wrap_err;
        logic [15:0] last_user;
        logic        stall;
        logic [48:0] prev;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = '0;
        m_if.tready = 1'b0;

        // ---- basic framing, len 4, tready high ----
        add(1'b1, 1'b0, 32'h0,         1'b0, 12'd4, 1'b0, 32'h0,         1'b0, 16'd0, 1'b0, 32'd0);
        add(1'b0, 1'b1, 32'h0001_0000, 1'b1, 12'd4, 1'b1, 32'h0001_0000, 1'b0, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0002_0000, 1'b1, 12'd4, 1'b1, 32'h0002_0000, 1'b0, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0003_0000, 1'b1, 12'd4, 1'b1, 32'h0003_0000, 1'b0, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0004_0000, 1'b1, 12'd4, 1'b1, 32'h0004_0000, 1'b1, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0005_0000, 1'b1, 12'd4, 1'b1, 32'h0005_0000, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0006_0000, 1'b1, 12'd4, 1'b1, 32'h0006_0000, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0007_0000, 1'b1, 12'd4, 1'b1, 32'h0007_0000, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'h0008_0000, 1'b1, 12'd4, 1'b1, 32'h0008_0000, 1'b1, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 12'd4, 1'b0, 32'h0,         1'b0, 16'd0, 1'b1, 32'd0);
        // ---- config 3 -> 5 mid-line, then config 0 ----
        add(1'b1, 1'b0, 32'h0,         1'b0, 12'd3, 1'b0, 32'h0,         1'b0, 16'd0, 1'b0, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0001, 1'b1, 12'd3, 1'b1, 32'hC0DE_0001, 1'b0, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0002, 1'b1, 12'd3, 1'b1, 32'hC0DE_0002, 1'b0, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0003, 1'b1, 12'd5, 1'b1, 32'hC0DE_0003, 1'b1, 16'd0, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0004, 1'b1, 12'd5, 1'b1, 32'hC0DE_0004, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0005, 1'b1, 12'd5, 1'b1, 32'hC0DE_0005, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0006, 1'b1, 12'd5, 1'b1, 32'hC0DE_0006, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0007, 1'b1, 12'd5, 1'b1, 32'hC0DE_0007, 1'b0, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0008, 1'b1, 12'd5, 1'b1, 32'hC0DE_0008, 1'b1, 16'd1, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_0009, 1'b1, 12'd0, 1'b1, 32'hC0DE_0009, 1'b1, 16'd2, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_000A, 1'b1, 12'd0, 1'b1, 32'hC0DE_000A, 1'b1, 16'd3, 1'b1, 32'd0);
        add(1'b0, 1'b1, 32'hC0DE_000B, 1'b1, 12'd0, 1'b1, 32'hC0DE_000B, 1'b1, 16'd4, 1'b1, 32'd0);
        add(1'b0, 1'b0, 32'h0,         1'b1, 12'd0, 1'b0, 32'h0,         1'b0, 16'd0, 1'b1, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge aclk);
            areset       = vecs[i].rst;
            s_if.tvalid  = vecs[i].vin;
            s_if.tdata   = vecs[i].din;
            m_if.tready  = vecs[i].rdy;
            cfg_line_len = vecs[i].cfg;
            @(posedge aclk);
            #1;
            check($sformatf("vec%0d m_tvalid", i), m_if.tvalid, vecs[i].ev);
            check($sformatf("vec%0d m_tdata", i), m_if.tdata, vecs[i].ed);
            check($sformatf("vec%0d m_tlast", i), m_if.tlast, vecs[i].el);
            check($sformatf("vec%0d m_tuser", i), m_if.tuser, vecs[i].eu);
            check($sformatf("vec%0d s_tready", i), s_if.tready, vecs[i].esr);
            check($sformatf("vec%0d drop", i), sts_drop_count, vecs[i].edrop);
        end

        // ---- overflow: 20 beats into a stalled 16-deep FIFO ----
        do_reset();
        cfg_line_len = 12'd4;
        for (int k = 1; k <= 20; k++) begin
            @(negedge aclk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'h0000_0100 * k;
            @(posedge aclk);
            #1;
            if (k == 15) check("ovf s_tready after 15", s_if.tready, 1'b1);
            if (k == 16) check("ovf s_tready after 16", s_if.tready, 1'b0);
            if (k == 17) check("ovf drop after 17", sts_drop_count, 32'd1);
        end
        check("ovf drop after 20", sts_drop_count, 32'd4);
        // full with simultaneous pop: the push is still dropped
        @(negedge aclk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hDEAD_BEEF;
        m_if.tready = 1'b1;
        check("ovf beat1 data", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata},
              {1'b1, 1'b0, 16'd0, 32'h0000_0100});
        @(posedge aclk);
        #1;
        check("ovf drop on full+pop", sts_drop_count, 32'd5);
        check("ovf s_tready after pop", s_if.tready, 1'b1);
        @(negedge aclk);
        s_if.tvalid = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            check($sformatf("ovf beat%0d", k), {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata},
                  {1'b1, (k % 4) == 0, 16'((k - 1) / 4), 32'h0000_0100 * k});
            @(negedge aclk);
        end
        check("ovf drained", m_if.tvalid, 1'b0);

        // ---- random backpressure, 1000 beats, len 7 ----
        do_reset();
        cfg_line_len = 12'd7;
        sent = 0; rcv = 0; nlast = 0; last_user = '0; stall = 1'b0; prev = '0;
        for (int cyc = 0; cyc < 20000 && rcv < 1000; cyc++) begin
            @(negedge aclk);
            if (stall)
                check("bp stall hold", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, prev});
            m_if.tready = 1'($urandom_range(0, 1));
            s_if.tvalid = s_if.tready && (sent < 1000) && ($urandom_range(0, 3) != 0);
            s_if.tdata  = 32'h5A00_0000 + sent;
            if (m_if.tvalid && m_if.tready) begin
                check($sformatf("bp beat%0d", rcv), {m_if.tuser, m_if.tlast, m_if.tdata},
                      {16'(rcv / 7), (rcv % 7) == 6, 32'h5A00_0000 + rcv});
                if (m_if.tlast) nlast++;
                last_user = m_if.tuser;
                rcv++;
            end
            if (s_if.tvalid) sent++;
            stall = m_if.tvalid && !m_if.tready;
            prev  = {m_if.tuser, m_if.tlast, m_if.tdata};
        end
        s_if.tvalid = 1'b0;
        check("bp beats received", rcv, 1000);
        check("bp tlast count", nlast, 142);
        check("bp final tuser", last_user, 16'd142);
        check("bp no drops", sts_drop_count, 32'd0);

        // ---- reset with a full FIFO mid-line ----
        do_reset();
        cfg_line_len = 12'd3;
        for (int k = 1; k <= 18; k++) begin
            @(negedge aclk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'h7700_0000 + k;
            @(posedge aclk);
        end
        #1;
        check("rst pre drop", sts_drop_count, 32'd2);
        @(negedge aclk);
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        @(posedge aclk);
        #1;
        check("rst outputs", {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata, s_if.tready}, 51'd0);
        check("rst drop cleared", sts_drop_count, 32'd0);
        @(negedge aclk);
        areset      = 1'b0;
        m_if.tready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge aclk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'hF000_0000 + k;
            @(posedge aclk);
            #1;
            check($sformatf("rst fresh beat%0d", k), {m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tdata},
                  {1'b1, k == 3, 16'd0, 32'hF000_0000 + k});
        end
        @(negedge aclk);
        s_if.tvalid = 1'b0;

        // ---- line index wrap: one-beat lines past 0xFFFF ----
        do_reset();
        cfg_line_len = 12'd0;
        m_if.tready  = 1'b1;
        wrap_err = 0;
        for (int n = 0; n <= 65536; n++) begin
            @(negedge aclk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'(n);
            @(posedge aclk);
            #1;
            if (m_if.tuser !== 16'(n) || m_if.tlast !== 1'b1 || m_if.tdata !== 32'(n)) wrap_err++;
            if (n == 65535) check("wrap tuser ffff", m_if.tuser, 16'hFFFF);
            if (n == 65536) check("wrap tuser 0", {m_if.tlast, m_if.tuser}, {1'b1, 16'h0000});
        end
        check("wrap sequence errors", wrap_err, 0);

        // ---- drop counter saturation ----
        do_reset();
        cfg_line_len = 12'd4;
        for (int k = 1; k <= 16; k++) begin
            @(negedge aclk);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'(k);
        end
        @(negedge aclk);
        force dut.drop_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.drop_cnt;
        @(posedge aclk);
        #1;
        check("sat reach max", sts_drop_count, 32'hFFFF_FFFF);
        @(posedge aclk);
        #1;
        check("sat hold max", sts_drop_count, 32'hFFFF_FFFF);
        @(negedge aclk);
        s_if.tvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axis_rti_line_packer.md
# axis_rti_line_packer

Downstream of the RTI controller's RAM readout port. Takes the paired up/down-chirp magnitude beats ({down, up}, MAG_WIDTH each) and buffers them in a small FIFO. It frames them into AXI-Stream lines of a configurable beat count, with `tlast` on each line's final beat and a line index on `tuser`, ready for DMA to the display host. The upstream source does not reliably honour backpressure, so beats arriving while the FIFO is full are dropped and counted.

## Interface
- `MAG_WIDTH`, 16, width of one magnitude sample; data beat is 2*MAG_WIDTH.
- `LINE_LEN_WIDTH`, 12, width of the line-length config.
- `FIFO_DEPTH_LOG2`, 4, FIFO holds 2**FIFO_DEPTH_LOG2 beats.

- `aclk`  in  1  clock; all logic on rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `cfg_line_len`  in  LINE_LEN_WIDTH  beats per line; 0 treated as 1.
- `s_axis_tdata`  in  2*MAG_WIDTH  {down, up} magnitude pair.
- `s_axis_tvalid`  in  1  input beat present.
- `s_axis_tready`  out  1  FIFO not full; advisory only.
- `m_axis_tdata`  out  2*MAG_WIDTH  buffered beat.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  last beat of a line.
- `m_axis_tuser`  out  16  line index of this beat.
- `sts_drop_count`  out  32  beats dropped on full, saturating.

## Operation
- **Accept rule.** An input beat is accepted when `s_axis_tvalid && count < DEPTH`.
  - `s_axis_tready = (count < DEPTH) && !areset`. It is combinational from count only and is independent of `m_axis_tready`.
- **Drop rule.** When `s_axis_tvalid && count == DEPTH`, the beat is discarded.
  - `sts_drop_count` increments, saturating at 0xFFFF_FFFF.
  - Line position and line index do not advance; dropped beats are invisible to framing.
- **FIFO.** Each entry stores {tuser[15:0], tlast, tdata}.
  - First-word-fall-through, registered output.
  - Pop occurs when `m_axis_tvalid && m_axis_tready`.
- **Framing.** Position counter `pos` (LINE_LEN_WIDTH bits) and line length register `len`.
  - On an accepted beat with `pos == 0`, `len` latches `max(cfg_line_len, 1)`. Config changes take effect only at line boundaries.
  - The stored tlast is `(pos == len_eff - 1)`, where `len_eff` is the value just latched when `pos == 0`, else `len`.
  - On an accepted tlast beat: `pos` goes to 0 and `line_idx` increments, wrapping 0xFFFF→0. Otherwise `pos` increments.
  - Stored tuser is the current `line_idx`.
- **Simultaneous push and pop.**
  - When `count < DEPTH`, count is unchanged and both operations complete.
  - When `count == DEPTH`, the push is dropped even if a pop occurs that cycle.
- **Reset.**
  - FIFO pointers, count, `pos`, `len`, `line_idx` and `sts_drop_count` all go to 0.
  - All outputs go to 0: `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`, `m_axis_tdata`, `s_axis_tready`.
  - Reset mid-line or mid-backpressure flushes all contents; no partial line survives. The first beat after reset starts line 0.
- **AXIS compliance.** While `m_axis_tvalid` is high and `m_axis_tready` is low, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` hold stable.

## Timing
- `s_axis_tready` rises in the first cycle with `areset` low.
- Latency is 1 cycle. A beat accepted at edge N into an empty FIFO gives `m_axis_tvalid` high after edge N, so it is visible in cycle N+1.
- Throughput is 1 beat/cycle in steady state with `m_axis_tready` held high.
- Full state:
  - `count` reaches DEPTH one edge after the DEPTH-th unpopped accept.
  - `s_axis_tready` drops in that same cycle.
  - The drop counter updates at the edge of the offending beat.
- Empty state: `m_axis_tvalid` falls the edge after the last pop if no push occurs that cycle.
- Pointers wrap modulo DEPTH. `count` is FIFO_DEPTH_LOG2+1 bits.

## Test plan
- **Basic framing.** `cfg_line_len=4`, `m_axis_tready=1`, 8 consecutive beats 0x0001_0000..0x0008_0000 → output identical data with 1-cycle latency. Expect tlast on beats 4 and 8, tuser=0 on beats 1–4 and tuser=1 on beats 5–8, `sts_drop_count=0`.
- **Overflow.** DEPTH=16, `m_axis_tready=0`, 20 beats → `s_axis_tready` low after the 16th and `sts_drop_count=4`. Then release ready: exactly beats 1–16 emerge in order, with tlast determined by accepted-beat position only.
- **Config change mid-line.** `cfg_line_len=3`; after beat 2, change to 5 → tlast on beat 3, then on beat 8. Config 0 → tlast on every beat, tuser incrementing each beat.
- **Backpressure stability.** Random `m_axis_tready` (50%), 1000 beats with `cfg_line_len=7` → output stable while stalled and no loss or duplication. Expect 142 tlasts and a final tuser of 142 on the last 6 beats.
- **Reset mid-operation.** Hold 10 beats in the FIFO mid-line, assert `areset` for 1 cycle → next cycle `m_axis_tvalid=0` and `sts_drop_count=0`. The next input beat exits with tuser=0 and starts a fresh line.
- **Wrap cases.** Force `line_idx` to 0xFFFF → the line after it carries tuser=0x0000. Force the drop counter near saturation → it holds at 0xFFFF_FFFF.
